// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : Memory-access / write-back stage: one req/ack data-memory
//            transaction (or none), then a single-cycle register-file write.
// Revision : 1.0
// ============================================================================
module mem_wb_stage #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] ALU_out,
    input  logic [31:0] RF_B,
    input  logic [4:0]  Rd,
    output logic        MEM_req,
    output logic        MEM_we,
    output logic [31:0] MEM_addr,
    output logic [31:0] MEM_wdata,
    input  logic [31:0] MEM_rdata,
    input  logic        MEM_ack,
    output logic        RF_WrEn,
    output logic [4:0]  RF_Awr,
    output logic [31:0] RF_WrData,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_ALU = 2'b00;
    localparam logic [1:0] c_OP_LW  = 2'b01;
    localparam logic [1:0] c_OP_LB  = 2'b10;
    localparam logic [1:0] c_OP_SW  = 2'b11;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYC);

    state_t      r_state, w_state;
    logic [1:0]  r_op, w_op;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [4:0]  r_rd, w_rd;
    logic [31:0] r_result, w_result;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_err, w_err;
    logic [7:0]  w_byte;

    // Little-endian lane select for byte loads.
    always_comb begin
        w_byte = MEM_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_byte = MEM_rdata[7:0];
            2'b01:   w_byte = MEM_rdata[15:8];
            2'b10:   w_byte = MEM_rdata[23:16];
            default: w_byte = MEM_rdata[31:24];
        endcase
    end

    always_comb begin
        w_state  = r_state;
        w_op     = r_op;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_rd     = r_rd;
        w_result = r_result;
        w_cnt    = r_cnt;
        w_err    = r_err;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_op    = Op;
                    w_addr  = ALU_out;
                    w_wdata = RF_B;
                    w_rd    = Rd;
                    w_cnt   = 8'd0;
                    w_err   = 1'b0;
                    if (Op == c_OP_ALU) begin
                        w_result = ALU_out;
                        w_state  = WB;
                    end else if ((Op == c_OP_LW || Op == c_OP_SW) && ALU_out[1:0] != 2'b00) begin
                        w_err   = 1'b1;
                        w_state = FIN;
                    end else begin
                        w_state = REQ;
                    end
                end
            end
            REQ: begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (MEM_ack) begin
                    case (r_op)
                        c_OP_LW: begin
                            w_result = MEM_rdata;
                            w_state  = WB;
                        end
                        c_OP_LB: begin
                            w_result = {24'd0, w_byte};
                            w_state  = WB;
                        end
                        default: w_state = FIN;
                    endcase
                end else begin
                    w_cnt = r_cnt + 8'd1;
                    if (r_cnt + 8'd1 == c_TIMEOUT) begin
                        w_err   = 1'b1;
                        w_state = FIN;
                    end
                end
            end
            WB: w_state = FIN;
            default: begin
                w_err   = 1'b0;
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_op     <= 2'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rd     <= 5'd0;
            r_result <= 32'd0;
            r_cnt    <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_op     <= w_op;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rd     <= w_rd;
            r_result <= w_result;
            r_cnt    <= w_cnt;
            r_err    <= w_err;
        end
    end

    assign MEM_req   = (r_state == REQ);
    assign MEM_we    = (r_state == REQ) && (r_op == c_OP_SW);
    assign MEM_addr  = r_addr;
    assign MEM_wdata = r_wdata;
    assign RF_WrEn   = (r_state == WB) && (r_rd != 5'd0);
    assign RF_Awr    = r_rd;
    assign RF_WrData = r_result;
    assign Busy      = (r_state != IDLE);
    assign Done      = (r_state == FIN);
    assign Error     = (r_state == FIN) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Self-checking bench for mem_wb_stage against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_mem_wb_stage;

    localparam int c_T = 15;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'd0;
    logic [31:0] ALU_out = 32'd0;
    logic [31:0] RF_B = 32'd0;
    logic [4:0]  Rd = 5'd0;
    logic        MEM_req, MEM_we, RF_WrEn, Busy, Done, Error;
    logic [31:0] MEM_addr, MEM_wdata, RF_WrData;
    logic [4:0]  RF_Awr;
    logic [31:0] MEM_rdata = 32'd0;
    logic        MEM_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    mem_wb_stage #(.TIMEOUT_CYC(c_T)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .ALU_out(ALU_out),
        .RF_B(RF_B), .Rd(Rd), .MEM_req(MEM_req), .MEM_we(MEM_we),
        .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_rdata(MEM_rdata),
        .MEM_ack(MEM_ack), .RF_WrEn(RF_WrEn), .RF_Awr(RF_Awr),
        .RF_WrData(RF_WrData), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    // One transaction. waits = REQ cycles without ack before the ack cycle;
    // waits >= c_T means ack never comes. fin_start pulses Start during Done.
    // Called at posedge+1 with the DUT idle.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] alu,
                           input logic [31:0] rfb, input logic [4:0] rd,
                           input int waits, input logic [31:0] rdata,
                           input bit fin_start, input string name);
        bit          misal, mem, tmo, wb, wren, err;
        int          nreq, total;
        logic [31:0] wbdata, sh;
        logic [5:0]  exp_ctl, got_ctl;
        misal = (op == 2'b01 || op == 2'b11) && (alu[1:0] != 2'b00);
        mem   = (op != 2'b00) && !misal;
        tmo   = mem && (waits >= c_T);
        nreq  = !mem ? 0 : (tmo ? c_T : waits + 1);
        wb    = (op == 2'b00) || (mem && !tmo && op != 2'b11);
        wren  = wb && (rd != 5'd0);
        err   = misal || tmo;
        sh    = rdata >> (8 * alu[1:0]);
        wbdata = (op == 2'b00) ? alu : (op == 2'b01) ? rdata : {24'd0, sh[7:0]};
        total = nreq + (wb ? 1 : 0) + 1;

        Start = 1'b1; Op = op; ALU_out = alu; RF_B = rfb; Rd = rd;
        MEM_ack = 1'($urandom); MEM_rdata = $urandom;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b, want 0 0", name, Busy, Done);
        end
        @(posedge Clk); #1;
        Start = 1'b0; Op = 2'($urandom); ALU_out = $urandom; RF_B = $urandom; Rd = 5'($urandom);

        for (int c = 1; c <= total; c++) begin
            bit in_req, in_wb, in_fin;
            in_req = (c <= nreq);
            in_wb  = wb && (c == nreq + 1);
            in_fin = (c == total);
            if (in_req) begin
                MEM_ack   = !tmo && (c - 1 == waits);
                MEM_rdata = MEM_ack ? rdata : $urandom;
            end else begin
                MEM_ack   = 1'($urandom);
                MEM_rdata = $urandom;
            end
            if (in_fin && fin_start) begin
                Start = 1'b1; Op = 2'b00; ALU_out = $urandom; Rd = 5'd7;
            end
            exp_ctl = {in_req, in_req && op == 2'b11, in_wb && wren, 1'b1, in_fin, in_fin && err};
            @(negedge Clk);
            got_ctl = {MEM_req, MEM_we, RF_WrEn, Busy, Done, Error};
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++;
                $display("FAIL %s ctl cyc%0d: req/we/wren/busy/done/err=%b, want %b",
                         name, c, got_ctl, exp_ctl);
            end
            if (in_req) begin
                checks++;
                if (MEM_addr !== alu || (op == 2'b11 && MEM_wdata !== rfb)) begin
                    errors++;
                    $display("FAIL %s mem cyc%0d: addr=%h wdata=%h, want %h %h",
                             name, c, MEM_addr, MEM_wdata, alu, rfb);
                end
            end
            if (in_wb && wren) begin
                checks++;
                if (RF_Awr !== rd || RF_WrData !== wbdata) begin
                    errors++;
                    $display("FAIL %s wb cyc%0d: awr=%0d data=%h, want %0d %h",
                             name, c, RF_Awr, RF_WrData, rd, wbdata);
                end
            end
            @(posedge Clk); #1;
            Start = 1'b0;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b1; Op = 2'b01; ALU_out = $urandom; MEM_ack = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({MEM_req, MEM_we, RF_WrEn, Busy, Done, Error} !== 6'd0 ||
            MEM_addr !== 32'd0 || MEM_wdata !== 32'd0 || RF_Awr !== 5'd0 || RF_WrData !== 32'd0) begin
            errors++;
            $display("FAIL reset: ctl=%b addr=%h wdata=%h awr=%0d wrdata=%h, want all 0",
                     {MEM_req, MEM_we, RF_WrEn, Busy, Done, Error}, MEM_addr, MEM_wdata, RF_Awr, RF_WrData);
        end
        @(posedge Clk); #1;
        Start = 1'b0; MEM_ack = 1'b0; Reset = 1'b1;
    endtask

    task automatic test_directed();
        run_txn(2'b00, 32'h0000_1234, $urandom, 5'd5, 0, $urandom, 1'b0, "alu");
        run_txn(2'b01, 32'h0000_0100, $urandom, 5'd9, 3, 32'hDEAD_BEEF, 1'b0, "lw_wait3");
        run_txn(2'b10, 32'h0000_0103, $urandom, 5'd3, 0, 32'hA1B2_C3D4, 1'b0, "lb_lane3");
        run_txn(2'b10, 32'h0000_0101, $urandom, 5'd3, 1, 32'hA1B2_C3D4, 1'b0, "lb_lane1");
        run_txn(2'b11, 32'h0000_0200, 32'h55AA_55AA, 5'd4, 0, $urandom, 1'b0, "sw");
        run_txn(2'b01, 32'h0000_0102, $urandom, 5'd6, 0, $urandom, 1'b0, "lw_misaligned");
        run_txn(2'b11, 32'h0000_0300, $urandom, 5'd1, c_T + 5, $urandom, 1'b0, "sw_timeout");
        run_txn(2'b01, 32'h0000_0400, $urandom, 5'd2, c_T - 1, 32'h1357_9BDF, 1'b0, "lw_ack_at_limit");
        run_txn(2'b00, 32'hCAFE_F00D, $urandom, 5'd0, 0, $urandom, 1'b0, "alu_rd0");
        run_txn(2'b00, 32'h0BAD_CAFE, $urandom, 5'd8, 0, $urandom, 1'b1, "start_in_fin");
        run_txn(2'b10, 32'h0000_0503, $urandom, 5'd11, 0, 32'h8899_AABB, 1'b0, "lb_no_align_check");
    endtask

    task automatic test_reset_mid_req();
        Start = 1'b1; Op = 2'b01; ALU_out = 32'h0000_0600; Rd = 5'd12; MEM_ack = 1'b0;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++;
        if (MEM_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req setup: req=%b, want 1", MEM_req);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({MEM_req, MEM_we, RF_WrEn, Busy, Done, Error} !== 6'd0 ||
            MEM_addr !== 32'd0 || MEM_wdata !== 32'd0 || RF_Awr !== 5'd0 || RF_WrData !== 32'd0) begin
            errors++;
            $display("FAIL mid_req reset: ctl=%b addr=%h, want all 0",
                     {MEM_req, MEM_we, RF_WrEn, Busy, Done, Error}, MEM_addr);
        end
        @(posedge Clk); #1;
        Reset = 1'b1;
        run_txn(2'b01, 32'h0000_0700, $urandom, 5'd13, 1, 32'h2468_ACE0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] alu;
            int          r, waits;
            op  = 2'($urandom_range(0, 3));
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            waits = (r < 7) ? (r % 4) : (r == 7) ? c_T - 1 : c_T + 2;
            run_txn(op, alu, $urandom, 5'($urandom), waits, $urandom,
                    1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_txn(2'b11, 32'h0000_0800, 32'h0F0F_0F0F, 5'd1, 0, $urandom, 1'b0, "b2b_sw");
        run_txn(2'b01, 32'h0000_0804, $urandom, 5'd31, 0, 32'h7777_1111, 1'b0, "b2b_lw");
        run_txn(2'b00, 32'h0000_0042, $urandom, 5'd30, 0, $urandom, 1'b0, "b2b_alu");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge Clk); #1;
        test_reset();
        test_directed();
        test_reset_mid_req();
        test_back_to_back();
        test_random();
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Multi-cycle memory-access and write-back stage that consumes the ALU stage result. It captures the ALU result (a value or an effective address), store data and destination register on a start pulse. It then runs one data-memory transaction over a req/ack handshake, or none for pure ALU ops, and drives a single-cycle register-file write. Completion and error are reported to the control FSM.

## Interface
Parameters:
- TIMEOUT_CYC, 15: maximum REQ cycles without MEM_ack before aborting with Error; legal range 1..255.

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-low; sampled on the rising Clk edge
- Start  input  1  one-cycle request; accepted only in IDLE
- Op  input  2  00 ALU write-back, 01 load word, 10 load byte zero-extended, 11 store word
- ALU_out  input  32  ALU result / effective byte address
- RF_B  input  32  store data
- Rd  input  5  destination register
- MEM_req  output  1  memory request, held until ack
- MEM_we  output  1  1 = write (store)
- MEM_addr  output  32  captured byte address
- MEM_wdata  output  32  captured store data
- MEM_rdata  input  32  read word, valid when MEM_ack=1
- MEM_ack  input  1  memory accept/complete, sampled only in REQ
- RF_WrEn  output  1  register-file write enable, one cycle
- RF_Awr  output  5  write address
- RF_WrData  output  32  write data
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle completion pulse
- Error  output  1  valid with Done; 1 = misaligned or timeout

## Operation
- States: IDLE, REQ, WB, FIN. All outputs are Moore outputs decoded from registered state and data.
- IDLE, Start=1: capture Op, ALU_out (as addr), RF_B, Rd, and clear the timeout counter. Next state:
  - Op=00 → WB, with result = ALU_out.
  - Op=01 or 11 with addr[1:0]≠00 → FIN with the error flag set. No memory access occurs.
  - Otherwise → REQ.
- IDLE, Start=0: remain in IDLE.
- REQ: MEM_req=1. MEM_we=1 only for Op=11. MEM_addr and MEM_wdata hold the captured values, stable for the whole request.
  - On MEM_ack=1, for Op=01: result = MEM_rdata → WB.
  - On MEM_ack=1, for Op=10: result = {24'b0, selected byte}, little-endian. addr[1:0]=00 selects rdata[7:0], 11 selects rdata[31:24] → WB.
  - On MEM_ack=1, for Op=11: → FIN, no write-back.
  - On MEM_ack=0: increment the counter. When the counter reaches TIMEOUT_CYC, go to FIN with the error flag set and drop MEM_req.
- WB: RF_WrEn=1, RF_Awr=Rd, RF_WrData=result. RF_WrEn is forced to 0 when Rd=0, but the state still passes through WB. → FIN.
- FIN: Done=1 and Error=error flag. The error flag is cleared on exit. → IDLE.
- Start outside IDLE is ignored, including during the FIN cycle. MEM_ack outside REQ is ignored.
- Byte loads have no alignment check.

## Timing
- Reset (Reset=0 at an edge) forces the following, from any state including mid-request:
  - state = IDLE;
  - MEM_req, MEM_we, RF_WrEn, Busy, Done and Error = 0;
  - MEM_addr, MEM_wdata, RF_Awr and RF_WrData = 0;
  - counter and error flag = 0.
- A pending memory request is abandoned without waiting for ack.
- Latencies are measured from the edge where Start is sampled (edge 0):
  - ALU op: RF_WrEn during cycle 1, Done during cycle 2.
  - Load, ack in the first REQ cycle: REQ in cycle 1, RF_WrEn in cycle 2, Done in cycle 3. Each wait cycle adds 1.
  - Store, ack in the first REQ cycle: Done in cycle 2.
  - Misaligned word access: Done with Error in cycle 1, and MEM_req is never asserted.
  - Timeout: MEM_req is high for exactly TIMEOUT_CYC cycles, then Done with Error in the next cycle.
- Ack arriving in the same cycle the counter reaches TIMEOUT_CYC: ack wins and the transaction completes normally.
- Back-to-back: the earliest the next Start can be accepted is the cycle after Done.

## Test plan
- Reset then ALU op: Op=00, ALU_out=0x0000_1234, Rd=5, Start pulse → RF_WrEn=1 with RF_Awr=5 and RF_WrData=0x1234 in cycle 1; Done=1, Error=0 in cycle 2.
- Load word with 3 wait cycles: Op=01, addr=0x100; ack on the 4th REQ cycle with rdata=0xDEAD_BEEF → MEM_req high for 4 cycles with MEM_we=0 and MEM_addr=0x100; then write-back of 0xDEADBEEF; then Done.
- Load byte lanes: addr=0x103, rdata=0xA1B2_C3D4 → RF_WrData=0x0000_00A1. Repeat with addr=0x101 → 0x0000_00C3.
- Store word: Op=11, addr=0x200, RF_B=0x55AA_55AA, ack in the first cycle → MEM_we=1 and MEM_wdata=0x55AA55AA; no RF_WrEn; Done in cycle 2.
- Errors:
  - lw at 0x102 → Done=Error=1 in cycle 1, with MEM_req never high.
  - sw with ack never asserted, TIMEOUT_CYC=15 → MEM_req high for 15 cycles, then Done=Error=1.
- Corner cases:
  - Rd=0 ALU op → no RF_WrEn, but Done still follows in cycle 2.
  - Reset=0 during REQ → MEM_req=0 and all outputs 0 on the next edge; a Start pulse after reset is accepted normally.
  - Start asserted during FIN → ignored.
